alu_arb: RTL and testbench

ALU_ARB -- requirements
Module: alu_arb

---
 rtl/alu_arb.sv | 105 ++++++++++
 tb/tb_alu_arb.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/alu_arb.sv
// Two-requester front end for a shared 32-bit ALU. Grants are round-robin and
// each result is held in a single registered slot until the consumer takes it.

module alu_arb_alu (
    input  logic [2:0]  i_ctrl,
    input  logic [31:0] i_a,
    input  logic [31:0] i_b,
    output logic [31:0] o_y
);
    logic [31:0] w_diff;

    always_comb begin
        w_diff = i_a - i_b;
        o_y    = 32'd0;
        case (i_ctrl)
            3'b000:  o_y = i_a & i_b;
            3'b001:  o_y = i_a | i_b;
            3'b010:  o_y = i_a + i_b;
            3'b100:  o_y = i_a & i_b;
            3'b101:  o_y = ~(i_a | i_b);
            3'b110:  o_y = w_diff;
            3'b111:  o_y = {31'd0, w_diff[31]};
            default: o_y = 32'd0;
        endcase
    end
endmodule

module alu_arb (
    input  logic        clk,
    input  logic        rst,
    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic [2:0]  req0_ctrl,
    input  logic [31:0] req0_a,
    input  logic [31:0] req0_b,
    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic [2:0]  req1_ctrl,
    input  logic [31:0] req1_a,
    input  logic [31:0] req1_b,
    output logic        res_valid,
    input  logic        res_ready,
    output logic [31:0] res_data,
    output logic        res_id
);
    typedef enum logic {S_EMPTY = 1'b0, S_FULL = 1'b1} state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic        r_prio;
    logic [31:0] r_res_data;
    logic        r_res_id;

    logic        w_accept;
    logic        w_grant;
    logic        w_gnt_id;
    logic [2:0]  w_ctrl;
    logic [31:0] w_a;
    logic [31:0] w_b;
    logic [31:0] w_alu_y;

    alu_arb_alu u_alu (
        .i_ctrl (w_ctrl),
        .i_a    (w_a),
        .i_b    (w_b),
        .o_y    (w_alu_y)
    );

    // Readies are gated by rst so nothing can be handed over while in reset.
    always_comb begin
        w_accept    = !rst && ((r_state == S_EMPTY) || res_ready);
        w_grant     = w_accept && (req0_valid || req1_valid);
        w_gnt_id    = (req0_valid && req1_valid) ? r_prio : req1_valid;
        w_ctrl      = w_gnt_id ? req1_ctrl : req0_ctrl;
        w_a         = w_gnt_id ? req1_a    : req0_a;
        w_b         = w_gnt_id ? req1_b    : req0_b;
        req0_ready  = w_grant && !w_gnt_id;
        req1_ready  = w_grant &&  w_gnt_id;
        w_state_nxt = r_state;
        if (w_grant)
            w_state_nxt = S_FULL;
        else if ((r_state == S_FULL) && res_ready)
            w_state_nxt = S_EMPTY;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= S_EMPTY;
            r_prio     <= 1'b0;
            r_res_data <= 32'd0;
            r_res_id   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_grant) begin
                r_res_data <= w_alu_y;
                r_res_id   <= w_gnt_id;
                r_prio     <= ~w_gnt_id;
            end
        end
    end

    assign res_valid = (r_state == S_FULL);
    assign res_data  = r_res_data;
    assign res_id    = r_res_id;
endmodule

// File: tb/tb_alu_arb.sv
// Bench for alu_arb: vector table for ALU codes, plus reset, alternation,
// backpressure and drain sequences, checked through a result scoreboard.

module tb_alu_arb;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        req0_valid, req1_valid;
    logic        req0_ready, req1_ready;
    logic [2:0]  req0_ctrl, req1_ctrl;
    logic [31:0] req0_a, req0_b, req1_a, req1_b;
    logic        res_valid, res_ready, res_id;
    logic [31:0] res_data;

    alu_arb dut (
        .clk        (clk),
        .rst        (rst),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_ctrl  (req0_ctrl),
        .req0_a     (req0_a),
        .req0_b     (req0_b),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_ctrl  (req1_ctrl),
        .req1_a     (req1_a),
        .req1_b     (req1_b),
        .res_valid  (res_valid),
        .res_ready  (res_ready),
        .res_data   (res_data),
        .res_id     (res_id)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        id;
        logic [2:0]  ctrl;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
    } vec_t;

    typedef struct packed {
        logic        id;
        logic [31:0] data;
    } sb_t;

    vec_t        vecs[9];
    sb_t         sb[$];
    int          n_tests = 0;
    int          n_fail  = 0;
    logic [31:0] exp0, exp1;
    logic        last_g0, last_g1;
    logic [31:0] saved_data;
    logic        saved_id;

    function automatic logic [31:0] alu_model(input logic [2:0] c, input logic [31:0] a,
                                              input logic [31:0] b);
        logic [31:0] d;
        d = a - b;
        case (c)
            3'b000:  return a & b;
            3'b001:  return a | b;
            3'b010:  return a + b;
            3'b100:  return a & b;
            3'b101:  return ~(a | b);
            3'b110:  return d;
            3'b111:  return {31'd0, d[31]};
            default: return 32'd0;
        endcase
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic set_req(input logic id, input logic v, input logic [2:0] c,
                           input logic [31:0] a, input logic [31:0] b, input logic [31:0] e);
        if (!id) begin
            req0_valid = v; req0_ctrl = c; req0_a = a; req0_b = b; exp0 = e;
        end else begin
            req1_valid = v; req1_ctrl = c; req1_a = a; req1_b = b; exp1 = e;
        end
    endtask

    task automatic rand_req(input logic id);
        logic [2:0]  c;
        logic [31:0] a, b;
        c = 3'($urandom_range(0, 7));
        a = $urandom;
        b = $urandom;
        set_req(id, 1'b1, c, a, b, alu_model(c, a, b));
    endtask

    // One clock: sample handshakes mid-cycle, then check the slot after the edge.
    task automatic step();
        logic g0, g1;
        sb_t  e;
        @(negedge clk);
        g0 = req0_ready;
        g1 = req1_ready;
        if (g0 && g1) chk("rdy_onehot", {31'd0, g1}, 32'd0);
        if (g0 && !req0_valid) chk("rdy0_without_valid", {31'd0, g0}, 32'd0);
        if (g1 && !req1_valid) chk("rdy1_without_valid", {31'd0, g1}, 32'd0);
        if (g0) sb.push_back({1'b0, exp0});
        if (g1) sb.push_back({1'b1, exp1});
        @(posedge clk);
        #1;
        if (g0 || g1) begin
            if (sb.size() == 0) begin
                chk("sb_underflow", 32'd1, 32'd0);
            end else begin
                e = sb.pop_front();
                chk("res_valid", {31'd0, res_valid}, 32'd1);
                chk("res_id", {31'd0, res_id}, {31'd0, e.id});
                chk("res_data", res_data, e.data);
            end
        end
        last_g0 = g0;
        last_g1 = g1;
    endtask

    initial begin
        vecs[0] = '{1'b0, 3'b010, 32'd5,        32'd7,        32'd12};
        vecs[1] = '{1'b1, 3'b110, 32'd3,        32'd5,        32'hFFFF_FFFE};
        vecs[2] = '{1'b1, 3'b111, 32'd3,        32'd5,        32'd1};
        vecs[3] = '{1'b1, 3'b101, 32'd0,        32'd0,        32'hFFFF_FFFF};
        vecs[4] = '{1'b0, 3'b010, 32'hFFFF_FFFF, 32'd1,       32'h0000_0000};
        vecs[5] = '{1'b0, 3'b000, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000};
        vecs[6] = '{1'b1, 3'b001, 32'h0F0F_0000, 32'h0000_00F0, 32'h0F0F_00F0};
        vecs[7] = '{1'b0, 3'b100, 32'hAAAA_5555, 32'hFFFF_0000, 32'hAAAA_0000};
        vecs[8] = '{1'b1, 3'b111, 32'd5,        32'd3,        32'd0};

        set_req(1'b0, 1'b1, 3'b010, 32'd1, 32'd1, 32'd2);
        set_req(1'b1, 1'b1, 3'b010, 32'd2, 32'd2, 32'd4);
        res_ready = 1'b1;
        last_g0 = 1'b0;
        last_g1 = 1'b0;

        // Power-on reset, with requests already pending.
        #1 rst = 1'b1;
        #2;
        chk("rst_res_valid", {31'd0, res_valid}, 32'd0);
        chk("rst_res_data", res_data, 32'd0);
        chk("rst_res_id", {31'd0, res_id}, 32'd0);
        chk("rst_readies", {30'd0, req1_ready, req0_ready}, 32'd0);
        @(posedge clk);
        #1;
        chk("rst_readies_after_edge", {30'd0, req1_ready, req0_ready}, 32'd0);
        set_req(1'b0, 1'b0, 3'b000, 32'd0, 32'd0, 32'd0);
        set_req(1'b1, 1'b0, 3'b000, 32'd0, 32'd0, 32'd0);
        rst = 1'b0;

        // Single-requester vectors.
        for (int i = 0; i < 9; i++) begin
            set_req(vecs[i].id, 1'b1, vecs[i].ctrl, vecs[i].a, vecs[i].b, vecs[i].exp);
            step();
            chk($sformatf("vec%0d_ready", i), {31'd0, vecs[i].id ? last_g1 : last_g0}, 32'd1);
            set_req(vecs[i].id, 1'b0, 3'b000, 32'd0, 32'd0, 32'd0);
            step();
            chk($sformatf("vec%0d_drain_valid", i), {31'd0, res_valid}, 32'd0);
            chk($sformatf("vec%0d_drain_hold", i), res_data, vecs[i].exp);
        end

        // Reset between edges while a result is held; prio is 1 at this point.
        res_ready = 1'b0;
        set_req(1'b0, 1'b1, 3'b001, 32'h0000_1234, 32'd0, 32'h0000_1234);
        step();
        set_req(1'b1, 1'b1, 3'b010, 32'd1, 32'd1, 32'd2);
        #2;
        rst = 1'b1;
        #1;
        chk("midrst_res_valid", {31'd0, res_valid}, 32'd0);
        chk("midrst_res_data", res_data, 32'd0);
        chk("midrst_res_id", {31'd0, res_id}, 32'd0);
        res_ready = 1'b1;
        #1;
        chk("midrst_readies", {30'd0, req1_ready, req0_ready}, 32'd0);
        sb.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Both requesters always valid: strict alternation starting at 0.
        rand_req(1'b0);
        rand_req(1'b1);
        for (int i = 0; i < 8; i++) begin
            step();
            chk($sformatf("alt%0d_valid", i), {31'd0, res_valid}, 32'd1);
            chk($sformatf("alt%0d_id", i), {31'd0, res_id}, (i % 2 == 0) ? 32'd0 : 32'd1);
            if (last_g0) rand_req(1'b0);
            if (last_g1) rand_req(1'b1);
        end

        // Backpressure: slot holds, no readies, then drain and regrant same edge.
        res_ready  = 1'b0;
        saved_data = res_data;
        saved_id   = res_id;
        for (int i = 0; i < 3; i++) begin
            step();
            chk($sformatf("bp%0d_readies", i), {30'd0, last_g1, last_g0}, 32'd0);
            chk($sformatf("bp%0d_valid", i), {31'd0, res_valid}, 32'd1);
            chk($sformatf("bp%0d_data", i), res_data, saved_data);
            chk($sformatf("bp%0d_id", i), {31'd0, res_id}, {31'd0, saved_id});
        end
        res_ready = 1'b1;
        step();
        chk("bp_release_grant0", {30'd0, last_g1, last_g0}, 32'd1);

        // Consumer takes the last result with no requests pending.
        saved_data = res_data;
        set_req(1'b0, 1'b0, 3'b000, 32'd0, 32'd0, 32'd0);
        set_req(1'b1, 1'b0, 3'b000, 32'd0, 32'd0, 32'd0);
        step();
        chk("empty_valid", {31'd0, res_valid}, 32'd0);
        chk("empty_data_hold", res_data, saved_data);
        chk("empty_id_hold", {31'd0, res_id}, 32'd0);
        chk("sb_leftover", sb.size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
